// File: rtl/cargador_memoria.sv
// -----------------------------------------------------------------------------
// cargador_memoria
//
// Purpose:
//   Loads one frame of FRAME_LEN bytes into a small memory. Each byte is taken
//   through a valid/ready handshake, then written on the following cycle with
//   a one-cycle write strobe. At the end of a frame, the block can raise a
//   one-cycle bank-clone request. It then pulses done and counts the frame.
//   A frame in progress can be cancelled with abort. Cancelling discards the
//   rest of the frame. Bytes already written are left in memory.
//
// Parameters:
//   FRAME_LEN   bytes per frame, 1..16
//   CLONE_CODE  value driven on flags during the clone request
//   CLONE_EN    1: issue the clone request at end of frame, 0: skip it
//
// Ports:
//   clk         single clock, rising edge
//   reset       asynchronous, active-low reset of all state
//   start       one-cycle request to begin a frame (honoured only in IDLE)
//   abort       synchronous cancel of the frame in progress
//   byte_in     incoming data byte
//   byte_valid  byte_in is valid this cycle
//   byte_ready  block accepts a byte this cycle (WAIT_BYTE only)
//   ADD         memory write address (held outside WRITE)
//   DAT         memory write data (held outside WRITE)
//   w           memory write strobe, one cycle per byte
//   flags       CLONE_CODE for one cycle during the clone request, else 0
//   busy        high in every state except IDLE
//   done        one-cycle pulse when a frame completes normally
//   frame_cnt   completed-frame counter, wraps 255 -> 0
// -----------------------------------------------------------------------------
module cargador_memoria #(
    parameter int unsigned FRAME_LEN  = 15,
    parameter logic [2:0]  CLONE_CODE = 3'b001,
    parameter bit          CLONE_EN   = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic [3:0] ADD,
    output logic [7:0] DAT,
    output logic       w,
    output logic [2:0] flags,
    output logic       busy,
    output logic       done,
    output logic [7:0] frame_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BYTE,
        WRITE,
        CLONE,
        DONE
    } state_t;

    // Index of the last byte in a frame. The index is 4 bits wide, so it can
    // address all 16 slots when FRAME_LEN = 16.
    localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] idx;
    logic       last_byte;

    assign last_byte = (idx == LAST_IDX);

    // Next-state decision. Abort overrides every other input outside IDLE.
    // In IDLE, abort also masks start, so "start + abort" has no effect.
    always_comb begin
        state_nxt = state;
        if (abort && (state != IDLE)) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:      if (start && !abort) state_nxt = WAIT_BYTE;
                WAIT_BYTE: if (byte_valid)      state_nxt = WRITE;
                WRITE: begin
                    if (!last_byte)    state_nxt = WAIT_BYTE;
                    else if (CLONE_EN) state_nxt = CLONE;
                    else               state_nxt = DONE;
                end
                CLONE:     state_nxt = DONE;
                DONE:      state_nxt = IDLE;
                default:   state_nxt = IDLE;
            endcase
        end
    end

    // State and registered outputs. Every output is derived from the state
    // being entered. Its value is therefore valid for the whole cycle spent
    // in that state, with no combinational path from the inputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            idx        <= '0;
            ADD        <= '0;
            DAT        <= '0;
            w          <= 1'b0;
            flags      <= '0;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            byte_ready <= (state_nxt == WAIT_BYTE);
            busy       <= (state_nxt != IDLE);
            w          <= (state_nxt == WRITE);
            flags      <= (state_nxt == CLONE) ? CLONE_CODE : 3'b000;
            done       <= (state_nxt == DONE);

            // A new frame always starts writing at slot 0.
            if ((state == IDLE) && (state_nxt == WAIT_BYTE))
                idx <= '0;

            // Capture the byte and its slot on the handshake. Both values
            // stay unchanged until the next accepted byte.
            if ((state == WAIT_BYTE) && (state_nxt == WRITE)) begin
                ADD <= idx;
                DAT <= byte_in;
            end

            // Advance only when another byte of this frame is expected. The
            // last slot never increments, so idx stays at or below LAST_IDX.
            if ((state == WRITE) && (state_nxt == WAIT_BYTE))
                idx <= idx + 4'd1;

            // DONE can be entered only from WRITE or CLONE, so this fires
            // once per completed frame. frame_cnt wraps naturally at 8 bits.
            if (state_nxt == DONE)
                frame_cnt <= frame_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_cargador_memoria.sv
// -----------------------------------------------------------------------------
// tb_cargador_memoria
//
// Two instances share one clock and reset:
//   u=0  defaults (FRAME_LEN=15, CLONE_EN=1)
//   u=1  FRAME_LEN=16, CLONE_EN=0
//
// The driver pushes expected writes, clone pulses and done pulses into
// queues, each tagged with the cycle in which it must appear. The
// negedge monitor pops these entries and compares them with the outputs.
// -----------------------------------------------------------------------------
module tb_cargador_memoria;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      start, abort, byte_valid;
    logic [1:0][7:0] byte_in;
    logic [1:0]      byte_ready, w, busy, done;
    logic [1:0][3:0] add;
    logic [1:0][7:0] dat;
    logic [1:0][2:0] flags;
    logic [1:0][7:0] frame_cnt;

    cargador_memoria dut0 (
        .clk(clk), .reset(reset), .start(start[0]), .abort(abort[0]),
        .byte_in(byte_in[0]), .byte_valid(byte_valid[0]), .byte_ready(byte_ready[0]),
        .ADD(add[0]), .DAT(dat[0]), .w(w[0]), .flags(flags[0]), .busy(busy[0]),
        .done(done[0]), .frame_cnt(frame_cnt[0])
    );

    cargador_memoria #(.FRAME_LEN(16), .CLONE_EN(1'b0)) dut1 (
        .clk(clk), .reset(reset), .start(start[1]), .abort(abort[1]),
        .byte_in(byte_in[1]), .byte_valid(byte_valid[1]), .byte_ready(byte_ready[1]),
        .ADD(add[1]), .DAT(dat[1]), .w(w[1]), .flags(flags[1]), .busy(busy[1]),
        .done(done[1]), .frame_cnt(frame_cnt[1])
    );

    function automatic int clone_en(int u);
        return (u == 0) ? 1 : 0;
    endfunction

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cy; int a; int d; } wexp_t;
    typedef struct { int cy; int fc; } dexp_t;
    wexp_t wq0[$], wq1[$];
    int    cq0[$], cq1[$];
    dexp_t dq0[$], dq1[$];
    int    fc_model[2];

    task automatic chk(string nm, int u, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s u=%0d cyc=%0d: got %0d want %0d", nm, u, cyc, act, exp);
        end
    endtask

    task automatic push_w(int u, int cy, int a, int d);
        wexp_t e;
        e.cy = cy; e.a = a; e.d = d;
        if (u == 0) wq0.push_back(e); else wq1.push_back(e);
    endtask

    task automatic push_end(int u, int wcy);
        dexp_t e;
        if (clone_en(u) != 0) begin
            if (u == 0) cq0.push_back(wcy + 1); else cq1.push_back(wcy + 1);
        end
        fc_model[u] = (fc_model[u] + 1) % 256;
        e.cy = wcy + 1 + clone_en(u);
        e.fc = fc_model[u];
        if (u == 0) dq0.push_back(e); else dq1.push_back(e);
    endtask

    // Monitor: compare every strobe against the scoreboard.
    task automatic mon(int u);
        wexp_t we;
        dexp_t de;
        int    cc;
        int    n;
        if (w[u]) begin
            n = (u == 0) ? wq0.size() : wq1.size();
            if (n == 0) begin
                total++; bad++;
                $display("FAIL stray_write u=%0d cyc=%0d: got ADD=%0d DAT=%0h want no write",
                         u, cyc, add[u], dat[u]);
            end else begin
                if (u == 0) we = wq0.pop_front(); else we = wq1.pop_front();
                chk("write_add", u, int'(add[u]), we.a);
                chk("write_dat", u, int'(dat[u]), we.d);
                chk("write_cycle", u, cyc, we.cy);
            end
        end
        if (flags[u] != 3'b000) begin
            n = (u == 0) ? cq0.size() : cq1.size();
            if (n == 0) begin
                total++; bad++;
                $display("FAIL stray_clone u=%0d cyc=%0d: got flags=%0d want 0", u, cyc, flags[u]);
            end else begin
                if (u == 0) cc = cq0.pop_front(); else cc = cq1.pop_front();
                chk("clone_flags", u, int'(flags[u]), 1);
                chk("clone_cycle", u, cyc, cc);
            end
        end
        if (done[u]) begin
            n = (u == 0) ? dq0.size() : dq1.size();
            if (n == 0) begin
                total++; bad++;
                $display("FAIL stray_done u=%0d cyc=%0d: got done=1 want 0", u, cyc);
            end else begin
                if (u == 0) de = dq0.pop_front(); else de = dq1.pop_front();
                chk("done_frame_cnt", u, int'(frame_cnt[u]), de.fc);
                chk("done_cycle", u, cyc, de.cy);
            end
        end
        if (byte_ready[u] && (w[u] || !busy[u])) begin
            total++; bad++;
            $display("FAIL ready_state u=%0d cyc=%0d: got ready=1 w=%0d busy=%0d want ready only in WAIT_BYTE",
                     u, cyc, w[u], busy[u]);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            mon(0);
            mon(1);
        end
    end

    task automatic chk_reset_outputs(int u);
        chk("rst_ready", u, int'(byte_ready[u]), 0);
        chk("rst_add",   u, int'(add[u]), 0);
        chk("rst_dat",   u, int'(dat[u]), 0);
        chk("rst_w",     u, int'(w[u]), 0);
        chk("rst_flags", u, int'(flags[u]), 0);
        chk("rst_busy",  u, int'(busy[u]), 0);
        chk("rst_done",  u, int'(done[u]), 0);
        chk("rst_fcnt",  u, int'(frame_cnt[u]), 0);
    endtask

    // One frame. Entered and left at posedge+1.
    //   mode:     0 = data is the byte index, 1 = 8'h34, 2 = random
    //   abort_at: abort after this many accepted bytes (-1 = never)
    //   rst_at:   assert reset during the write of byte rst_at-1 (-1 = never)
    //   noise:    pulse start randomly while the frame is busy
    task automatic run_frame(int u, int nb, int mode, int maxgap,
                             int abort_at, int rst_at, bit noise);
        int acc = 0;
        int lastw = 0;
        int gap;
        int to;
        logic [7:0] d;
        start[u] = 1'b1;
        @(posedge clk); #1;
        start[u] = 1'b0;
        while (acc < nb) begin
            if (acc == abort_at) begin
                byte_valid[u] = 1'b0;
                if (acc > 0) begin @(posedge clk); #1; end
                abort[u] = 1'b1; byte_valid[u] = 1'b1; byte_in[u] = 8'hEE;
                @(negedge clk);
                chk("abort_in_wait", u, int'(byte_ready[u]), 1);
                @(posedge clk); #1;
                abort[u] = 1'b0; byte_valid[u] = 1'b0;
                @(negedge clk);
                chk("abort_busy", u, int'(busy[u]), 0);
                chk("abort_ready", u, int'(byte_ready[u]), 0);
                chk("abort_fcnt", u, int'(frame_cnt[u]), fc_model[u]);
                @(posedge clk); #1;
                return;
            end
            gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            if (gap > 0) byte_valid[u] = 1'b0;
            repeat (gap) begin
                if (noise) start[u] = 1'($urandom_range(1, 0));
                @(posedge clk); #1;
            end
            start[u] = 1'b0;
            case (mode)
                0:       d = 8'(acc);
                1:       d = 8'h34;
                default: d = 8'($urandom_range(255, 0));
            endcase
            byte_valid[u] = 1'b1; byte_in[u] = d;
            to = 0;
            forever begin
                @(negedge clk);
                if (byte_ready[u]) begin
                    push_w(u, cyc + 1, acc, int'(d));
                    lastw = cyc + 1;
                    break;
                end
                to++;
                if (to > 20) begin
                    total++; bad++;
                    $display("FAIL ready_timeout u=%0d byte=%0d: got no byte_ready want ready within 20 cycles", u, acc);
                    byte_valid[u] = 1'b0;
                    @(posedge clk); #1;
                    return;
                end
                @(posedge clk); #1;
            end
            @(posedge clk); #1;
            acc++;
            if (acc == rst_at) begin
                byte_valid[u] = 1'b0;
                @(negedge clk); #1;
                reset = 1'b0;
                #1;
                chk_reset_outputs(u);
                fc_model[0] = 0;
                fc_model[1] = 0;
                repeat (2) @(posedge clk);
                #1 reset = 1'b1;
                return;
            end
        end
        byte_valid[u] = 1'b0;
        push_end(u, lastw);
        to = 0;
        while (busy[u] && to < 20) begin
            @(posedge clk); #1;
            to++;
        end
        chk("frame_end_idle", u, int'(busy[u]), 0);
    endtask

    initial begin
        start = '0; abort = '0; byte_valid = '0; byte_in = '0;
        fc_model[0] = 0; fc_model[1] = 0;

        // Outputs while reset is held from time 0.
        #2;
        chk_reset_outputs(0);
        chk_reset_outputs(1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;

        // Back-to-back bytes 0..14 with valid held high.
        run_frame(0, 15, 0, 0, -1, -1, 1'b0);
        chk("fcnt_after_first", 0, int'(frame_cnt[0]), 1);

        // Constant data with random valid gaps.
        run_frame(0, 15, 1, 5, -1, -1, 1'b0);

        // Abort after 7 bytes, then a full frame that must restart at ADD 0.
        run_frame(0, 15, 2, 2, 7, -1, 1'b0);
        run_frame(0, 15, 0, 1, -1, -1, 1'b0);
        run_frame(0, 15, 2, 0, 0, -1, 1'b0);

        // Abort in IDLE (with and without start) has no effect.
        start[0] = 1'b1; abort[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        @(posedge clk); #1;
        abort[0] = 1'b0;
        @(negedge clk);
        chk("idle_abort_busy", 0, int'(busy[0]), 0);
        chk("idle_abort_fcnt", 0, int'(frame_cnt[0]), fc_model[0]);
        @(posedge clk); #1;

        // Reset during the write of ADD 9 discards the frame.
        run_frame(0, 15, 0, 0, -1, 10, 1'b0);
        @(posedge clk); #1;

        // Sixteen-byte frames without the clone request.
        run_frame(1, 16, 2, 2, -1, -1, 1'b0);
        run_frame(1, 16, 0, 0, -1, -1, 1'b0);
        chk("u1_fcnt", 1, int'(frame_cnt[1]), 2);

        // 256 frames wrap frame_cnt; stray starts while busy are ignored.
        for (int f = 0; f < 256; f++)
            run_frame(0, 15, 2, 1, -1, -1, 1'b1);
        chk("fcnt_wrap", 0, int'(frame_cnt[0]), 0);

        repeat (4) @(posedge clk);
        #1;
        chk("left_writes_u0", 0, wq0.size(), 0);
        chk("left_writes_u1", 1, wq1.size(), 0);
        chk("left_clones_u0", 0, cq0.size(), 0);
        chk("left_dones_u0",  0, dq0.size(), 0);
        chk("left_dones_u1",  1, dq1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
